// File: rtl/sram_rr_port_ctrl_pkg.sv
// sram_ctrl_pkg: sequencer state encoding and pointer/index width helper
package sram_ctrl_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_rr_port_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at the pointer, pointer moves past each winner
module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  int j;
  // descending scan so the candidate closest to the pointer is written last and wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (en_i && req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
    ptr_d = (|gnt_o) ? IW'((int'(idx_o) + 1) % NUM_REQ) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/sram_rr_port_ctrl.sv
// sram_rr_port_ctrl: zero-fills a single-port SRAM after reset, then shares it round-robin
module sram_rr_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_din,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             init_done,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);
  localparam int IW = idx_w(NUM_REQ);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q, last_addr_q;
  logic [NUM_REQ-1:0]    gnt, rsp_valid_q;
  logic [IW-1:0]         idx;
  logic                  run;
  assign run       = state_q == ST_RUN;
  assign req_ready = gnt;
  assign init_done = run;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = mem_dout;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (run),
    .req_i (req_valid),
    .gnt_o (gnt),
    .idx_o (idx)
  );
  always_comb begin
    mem_we   = run ? ((|gnt) && req_we[idx]) : 1'b1;
    mem_addr = !run ? cnt_q : (|gnt) ? req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH] : last_addr_q;
    mem_din  = (run && (|gnt)) ? req_din[int'(idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  // reads granted this cycle are tagged so the SRAM's registered dout is claimed next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      last_addr_q <= '0;
      rsp_valid_q <= '0;
    end else begin
      last_addr_q <= mem_addr;
      rsp_valid_q <= gnt & ~req_we;
      if (!run) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) state_q <= ST_RUN;
      end
    end
  end
endmodule

// File: tb/tb_sram_rr_port_ctrl.sv
// tb_sram_rr_port_ctrl: directed stimulus, behavioural SRAM/arbiter model and literal spot checks
module tb_sram_rr_port_ctrl;
  localparam int N = 2, AW = 4, DW = 8, DEPTH = 1 << AW;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic          init_done, mem_we;
  int checks = 0, passes = 0;
  logic [DW-1:0] sram [DEPTH] = '{default: 8'hEE};
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr = 0, m_init = 0, m_last = 0, m_g = 0;
  logic [N-1:0]  m_rsp_v = '0;
  logic [DW-1:0] m_rsp_d = '0, m_d = '0;
  logic [AW-1:0] m_a = '0;
  logic [1:0]    seq [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;

  sram_rr_port_ctrl #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_init_done", init_done, 0);
      m_ptr = 0;
      m_init = 0;
      m_rsp_v = '0;
    end else begin
      chk("init_done", init_done, m_init == DEPTH);
      chk("rsp_valid", rsp_valid, m_rsp_v);
      if (m_rsp_v != 0) chk("rsp_data", rsp_data, m_rsp_d);
      m_rsp_v = '0;
      if (m_init < DEPTH) begin
        chk("init_ready", req_ready, 0);
        chk("init_we", mem_we, 1);
        chk("init_addr", mem_addr, m_init);
        chk("init_din", mem_din, 0);
        m_mem[m_init] = '0;
        m_last = m_init;
        m_init++;
      end else begin
        m_g = -1;
        for (int k = 0; k < N; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        if (m_g < 0) begin
          chk("idle_ready", req_ready, 0);
          chk("idle_we", mem_we, 0);
          chk("idle_addr", mem_addr, m_last);
          chk("idle_din", mem_din, 0);
        end else begin
          m_a = req_addr[m_g*AW +: AW];
          m_d = req_din[m_g*DW +: DW];
          chk("grant", req_ready, 1 << m_g);
          chk("mem_we", mem_we, req_we[m_g]);
          chk("mem_addr", mem_addr, m_a);
          if (req_we[m_g]) begin
            chk("mem_din", mem_din, m_d);
            m_mem[m_a] = m_d;
          end else begin
            m_rsp_v = N'(1) << m_g;
            m_rsp_d = m_mem[m_a];
          end
          m_last = m_a;
          m_ptr = (m_g + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] we, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_we = we;
    req_addr = {a1, a0};
    req_din = {d1, d0};
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 40) begin
      tick();
      n++;
    end
    chk("init_latency", n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    peek();
    chk("lit_rst_ready", req_ready, 0);
    chk("lit_rst_done", init_done, 0);
    tick();
    rst_n = 1'b1;
    wait_init();
    for (int a = 0; a < DEPTH; a++) begin
      drive(2'b01, 2'b00, AW'(a), 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    peek();
    chk("lit_zero_valid", rsp_valid, 2'b01);
    chk("lit_zero_data", rsp_data, 8'h00);
    tick();
    drive(2'b01, 2'b01, 3, 0, 8'hA5, 0);
    tick();
    drive(2'b01, 2'b00, 3, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    peek();
    chk("lit_wr_rd_valid", rsp_valid, 2'b01);
    chk("lit_wr_rd_data", rsp_data, 8'hA5);
    tick();
    drive(2'b11, 2'b11, 1, 2, 8'h31, 8'h42);
    tick();
    tick();
    drive(2'b11, 2'b00, 1, 2, 0, 0);
    for (int k = 0; k < 4; k++) begin
      peek();
      chk("lit_rr_grant", req_ready, seq[k]);
      if (k > 0) begin
        chk("lit_rr_rsp", rsp_valid, seq[k-1]);
        chk("lit_rr_data", rsp_data, seq[k-1] == 2'b01 ? 8'h31 : 8'h42);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    peek();
    chk("lit_rr_last_rsp", rsp_valid, 2'b01);
    chk("lit_rr_last_data", rsp_data, 8'h31);
    tick();
    drive(2'b01, 2'b01, 5, 0, 8'h11, 0);
    tick();
    drive(2'b01, 2'b00, 5, 0, 0, 0);
    tick();
    drive(2'b10, 2'b10, 0, 5, 0, 8'h22);
    peek();
    chk("lit_rf_valid", rsp_valid, 2'b01);
    chk("lit_rf_old", rsp_data, 8'h11);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(2'b01, 2'b00, 5, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    peek();
    chk("lit_rf_new", rsp_data, 8'h22);
    tick();
    drive(2'b01, 2'b00, 5, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    peek();
    chk("lit_rst_drop", rsp_valid, 2'b00);
    tick();
    drive(2'b11, 2'b00, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    wait_init();
    peek();
    chk("lit_first_grant", req_ready, 2'b01);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(2'b01, 2'b00, 5, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    peek();
    chk("lit_refill_valid", rsp_valid, 2'b01);
    chk("lit_refill_data", rsp_data, 8'h00);
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
